shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the n-bit bitshift_reg: serializes up to MSB bits of a parallel command word into the register's serial input and drives its en/dir pins.
Accepts one command at a time over a valid/ready handshake and supports stall (hold) and abort.
Pulses done when a command completes.
Sits between a host/config block and a bitshift_reg instance, whose clk/rstn it shares.

Parameters:
MSB, 16, width of the controlled shift register and of cmd_data.
CNTW, $clog2(MSB+1) (5 at default), width of the length field and bit counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
rstn  input  1  reset, asynchronous, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command; equals (state==IDLE).
cmd_dir  input  1  shift direction to apply to bitshift_reg for this command.
cmd_len  input  CNTW  number of bits to shift; 0 allowed; values >MSB clamp to MSB.
cmd_data  input  MSB  bits to send, LSB first (cmd_data[0] first).
hold  input  1  stall: no bit consumed while high.
abort  input  1  terminate the current command.
sr_en  output  1  to bitshift_reg en.
sr_dir  output  1  to bitshift_reg dir.
sr_d  output  1  to bitshift_reg d.
busy  output  1  state != IDLE.
done  output  1  one-cycle completion pulse.
bit_cnt  output  CNTW  bits shifted in the current or last command.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. While rstn=0, outputs go low immediately, independent of clk: state=IDLE, data_q=0, len_q=0, dir_q=0, bit_cnt=0, done=0, sr_en=0, sr_d=0, sr_dir=0.
- States: IDLE, SHIFT, DONE (2-bit encoded).
- IDLE:
  - cmd_ready=1.
  - On posedge with cmd_valid=1: latch data_q=cmd_data, dir_q=cmd_dir, len_q=min(cmd_len,MSB); clear bit_cnt=0.
  - Next state is SHIFT if len_q>0, else DONE.
  - abort and hold are ignored in IDLE.
- SHIFT, combinational outputs:
  - sr_en = !hold && !abort.
  - sr_d = data_q[bit_cnt].
  - sr_dir = dir_q.
  - bitshift_reg consumes a bit on every posedge where sr_en=1.
- SHIFT, on posedge with sr_en=1:
  - bit_cnt += 1.
  - If bit_cnt was len_q-1, next state is DONE.
- SHIFT, on posedge with hold=1: everything frozen (no bit consumed, bit_cnt unchanged).
- SHIFT, abort:
  - abort=1 wins over hold; sr_en is already 0 in that cycle.
  - Next state is IDLE. No done pulse; bit_cnt keeps its partial value.
- DONE:
  - done=1 and sr_en=0 for exactly one cycle, then IDLE.
  - abort and hold are ignored.
- Outside SHIFT: sr_en=0, sr_d=0. sr_dir holds dir_q, so it is stable around the shift burst.
- Latency:
  - Command accepted at edge E0.
  - Bits are consumed at edges E1..E(len) when no hold is applied.
  - done is high during the cycle after E(len); cmd_ready returns one cycle later.
  - Cost: len+2 cycles per command, plus hold cycles.
  - len=0: done is high in the cycle after E0, and no sr_en pulse occurs.
- bit_cnt:
  - Holds its final value after DONE until the next accept.
  - Never exceeds len_q.
  - No wrap: the SHIFT exit happens at len_q ≤ MSB.
- Reset asserted mid-command: immediate return to IDLE with all outputs low. The partial data already in bitshift_reg is not restored.
- cmd_valid is ignored while busy; the host must hold the command until cmd_ready.

Test Plan:
1. Reset, then cmd_data=16'hA5C3, len=16, dir=0, hold=0 -> sr_en high for exactly 16 consecutive cycles; sr_d sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done single pulse 17 cycles after accept; bit_cnt=16; cmd_ready high the following cycle.
2. len=4, dir=1, data=16'h000A, hold high for 3 cycles after the 2nd bit -> sr_dir=1 throughout; sr_d sequence 0,1,0,1 with a 3-cycle sr_en gap; done 8 cycles after accept; bit_cnt=4.
3. len=0 -> no sr_en pulse; done high in the cycle after accept; bit_cnt=0. Then len=20 with MSB=16 -> exactly 16 bits shifted; bit_cnt=16.
4. len=10: abort after 5 bits, with hold asserted in the same cycle -> sr_en low in that cycle; IDLE next cycle; no done; bit_cnt=5. An immediate new command is accepted.
5. Deassert rstn asynchronously mid-SHIFT (between clock edges) -> sr_en, busy, done and bit_cnt go 0 without a clock edge. After release, a 3-bit command completes normally.
6. Back-to-back commands with cmd_valid held high: two len=2 commands -> accept gap of 4 cycles (2 shift + done + idle). cmd_valid pulses while busy are ignored (exactly 2 commands executed).

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: feeds up to MSB bits of a command word, LSB first, into a bitshift_reg via en/dir/d.
// Latency: len+2 cycles per command (accept edge, len shift edges, one done cycle), plus stalled cycles.
// Backpressure: cmd_ready only in IDLE; hold freezes the bit stream; abort drops the command without done.
module shift_seq_ctrl #(
  parameter int MSB  = 16,
  parameter int CNTW = $clog2(MSB + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_dir,
  input  logic [CNTW-1:0] cmd_len,
  input  logic [MSB-1:0]  cmd_data,
  input  logic            hold,
  input  logic            abort,
  output logic            sr_en,
  output logic            sr_dir,
  output logic            sr_d,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LP_LEN_MAX = CNTW'(MSB);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MSB-1:0]  r_data;
  logic [CNTW-1:0] r_len;
  logic [CNTW-1:0] r_bit_cnt;
  logic            r_dir;

  logic [CNTW-1:0] w_len_clamp;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic            w_cur_bit;

  // Lengths beyond the register width are clamped so the counter never needs to wrap.
  assign w_len_clamp = (cmd_len > LP_LEN_MAX) ? LP_LEN_MAX : cmd_len;
  assign w_accept    = (r_state == ST_IDLE) && cmd_valid;
  // A bit is consumed only in SHIFT when neither stalled nor aborted.
  assign w_step      = (r_state == ST_SHIFT) && !hold && !abort;
  assign w_last      = ((r_bit_cnt + CNTW'(1)) == r_len);
  // Select data bit at the current count without a narrow index (counter is one bit wider).
  assign w_cur_bit   = |(r_data & (MSB'(1) << r_bit_cnt));

  // State register; reset drops straight to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: abort beats hold in SHIFT; DONE always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = (w_len_clamp != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (!hold && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; sr_dir follows the latched direction so it is stable around a burst.
  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    sr_en     = w_step;
    sr_d      = (r_state == ST_SHIFT) ? w_cur_bit : 1'b0;
    sr_dir    = r_dir;
    bit_cnt   = r_bit_cnt;
  end

  // Command latch and bit counter; the counter keeps its last value until the next accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data    <= '0;
      r_len     <= '0;
      r_dir     <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_data    <= cmd_data;
      r_len     <= w_len_clamp;
      r_dir     <= cmd_dir;
      r_bit_cnt <= '0;
    end else if (w_step) begin
      r_bit_cnt <= r_bit_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed scenarios plus randomized commands against a transaction-level model.
// Cycle 0 is the cycle whose closing edge accepts a command; observations are taken 1 time unit after each negedge.
// Inputs are driven right after the negedge, so hold/abort affect the combinational outputs seen in that cycle.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [4:0]  cmd_len;
  logic [15:0] cmd_data;
  logic        hold;
  logic        abort;
  logic        sr_en;
  logic        sr_dir;
  logic        sr_d;
  logic        busy;
  logic        done;
  logic [4:0]  bit_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  shift_seq_ctrl #(.MSB(16), .CNTW(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .hold      (hold),
    .abort     (abort),
    .sr_en     (sr_en),
    .sr_dir    (sr_dir),
    .sr_d      (sr_d),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] low_mask(input int n);
    logic [16:0] m;
    m = (17'h1 << n) - 17'h1;
    return m[15:0];
  endfunction

  // Expected behaviour of one command from the rules: clamp, stop point, inserted stall cycles.
  task automatic model_cmd(input logic [4:0] len, input int hold_at, input int hold_n, input int abort_at,
                           output logic [63:0] en_mask, output int nbits, output int done_cyc,
                           output int ndone, output int ready_cyc, output logic [4:0] fin_cnt);
    int lc, stop, h;
    lc   = (int'(len) > 16) ? 16 : int'(len);
    stop = (abort_at >= 0 && abort_at < lc) ? abort_at : lc;
    h    = (hold_at >= 0 && hold_at < stop) ? hold_n : 0;
    en_mask = '0;
    for (int c = 1; c <= stop + h; c++) begin
      if (c <= hold_at || c > hold_at + h) en_mask[c] = 1'b1;
    end
    nbits = stop;
    if (stop < lc) begin
      done_cyc = -1; ndone = 0; fin_cnt = 5'(stop);
    end else begin
      done_cyc = stop + h + 1; ndone = 1; fin_cnt = 5'(lc);
    end
    ready_cyc = stop + h + 2;
  endtask

  // Issues one command and records what the DUT does until cmd_ready returns.
  task automatic run_cmd(input logic [15:0] data, input logic [4:0] len, input logic dir,
                         input int hold_at, input int hold_n, input int abort_at,
                         output logic [63:0] en_mask, output logic [15:0] bits, output int nbits,
                         output int done_cyc, output int ndone, output int ready_cyc,
                         output logic [4:0] fin_cnt, output int dir_err);
    int guard, hold_left;
    en_mask = '0; bits = '0; nbits = 0; done_cyc = -1; ndone = 0; ready_cyc = -1;
    fin_cnt = '0; dir_err = 0; hold_left = hold_n; guard = 0;
    @(negedge clk); #1;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL run_cmd_ready_wait got cmd_ready=0 want 1 within 100 cycles");
    end
    cmd_data = data; cmd_len = len; cmd_dir = dir; cmd_valid = 1'b1;
    for (int cyc = 1; cyc < 100 && ready_cyc < 0; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0; hold = 1'b0; abort = 1'b0;
      if (nbits == abort_at) begin
        abort = 1'b1; hold = 1'b1;
      end else if (nbits == hold_at && hold_left > 0) begin
        hold = 1'b1; hold_left--;
      end
      #1;
      if (sr_en) begin
        if (cyc < 64) en_mask[cyc] = 1'b1;
        if (nbits < 16) bits[nbits] = sr_d;
        nbits++;
      end
      if (sr_dir !== dir) dir_err++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cmd_ready) begin
        ready_cyc = cyc; fin_cnt = bit_cnt;
      end
    end
    hold = 1'b0; abort = 1'b0;
    if (ready_cyc < 0) begin
      n_checks++;
      $display("FAIL run_cmd_complete got no return to idle want idle within 100 cycles");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = '0; cmd_data = '0; hold = 1'b0; abort = 1'b0;
    #1 rstn = 1'b0;
    #2;
    n_checks++;
    if ({sr_en, sr_d, sr_dir, busy, done} !== 5'b0)
      $display("FAIL reset_outputs got en,d,dir,busy,done=%b want 00000", {sr_en, sr_d, sr_dir, busy, done});
    else n_pass++;
    n_checks++;
    if (bit_cnt !== 5'd0) $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_full16();
    logic [63:0] en; logic [15:0] bits; int nb, dc, nd, rc, de; logic [4:0] fc;
    run_cmd(16'hA5C3, 5'd16, 1'b0, -1, 0, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (en !== 64'h1FFFE) $display("FAIL full16_en got %h want 1fffe", en); else n_pass++;
    n_checks++; if (bits !== 16'hA5C3) $display("FAIL full16_bits got %h want a5c3", bits); else n_pass++;
    n_checks++; if (dc !== 17 || nd !== 1) $display("FAIL full16_done got cyc %0d n %0d want 17 1", dc, nd); else n_pass++;
    n_checks++; if (fc !== 5'd16) $display("FAIL full16_bit_cnt got %0d want 16", fc); else n_pass++;
    n_checks++; if (rc !== 18) $display("FAIL full16_ready got %0d want 18", rc); else n_pass++;
    n_checks++; if (de !== 0) $display("FAIL full16_dir got %0d errors want 0", de); else n_pass++;
  endtask

  task automatic test_hold();
    logic [63:0] en; logic [15:0] bits; int nb, dc, nd, rc, de; logic [4:0] fc;
    run_cmd(16'h000A, 5'd4, 1'b1, 2, 3, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (en !== 64'hC6) $display("FAIL hold_en got %h want c6", en); else n_pass++;
    n_checks++; if (bits !== 16'h000A || nb !== 4) $display("FAIL hold_bits got %h/%0d want a/4", bits, nb); else n_pass++;
    n_checks++; if (dc !== 8) $display("FAIL hold_done got %0d want 8", dc); else n_pass++;
    n_checks++; if (fc !== 5'd4) $display("FAIL hold_bit_cnt got %0d want 4", fc); else n_pass++;
    n_checks++; if (de !== 0) $display("FAIL hold_dir got %0d errors want 0", de); else n_pass++;
  endtask

  task automatic test_len0_clamp();
    logic [63:0] en; logic [15:0] bits, d; int nb, dc, nd, rc, de; logic [4:0] fc;
    run_cmd(16'hFFFF, 5'd0, 1'b0, -1, 0, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (en !== 64'h0) $display("FAIL len0_en got %h want 0", en); else n_pass++;
    n_checks++; if (dc !== 1 || nd !== 1) $display("FAIL len0_done got cyc %0d n %0d want 1 1", dc, nd); else n_pass++;
    n_checks++; if (fc !== 5'd0) $display("FAIL len0_bit_cnt got %0d want 0", fc); else n_pass++;
    d = 16'($urandom);
    run_cmd(d, 5'd20, 1'b1, -1, 0, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (nb !== 16 || bits !== d) $display("FAIL clamp_bits got %0d/%h want 16/%h", nb, bits, d); else n_pass++;
    n_checks++; if (fc !== 5'd16) $display("FAIL clamp_bit_cnt got %0d want 16", fc); else n_pass++;
    n_checks++; if (dc !== 17) $display("FAIL clamp_done got %0d want 17", dc); else n_pass++;
  endtask

  task automatic test_abort();
    logic [63:0] en; logic [15:0] bits, d; int nb, dc, nd, rc, de; logic [4:0] fc;
    d = 16'($urandom);
    run_cmd(d, 5'd10, 1'b0, -1, 0, 5, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (en !== 64'h3E) $display("FAIL abort_en got %h want 3e", en); else n_pass++;
    n_checks++; if (nd !== 0) $display("FAIL abort_no_done got %0d pulses want 0", nd); else n_pass++;
    n_checks++; if (fc !== 5'd5) $display("FAIL abort_bit_cnt got %0d want 5", fc); else n_pass++;
    n_checks++; if (rc !== 7) $display("FAIL abort_idle got %0d want 7", rc); else n_pass++;
    run_cmd(16'h0005, 5'd3, 1'b1, -1, 0, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (dc !== 4 || bits !== 16'h0005) $display("FAIL after_abort got done %0d bits %h want 4 5", dc, bits); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [63:0] en; logic [15:0] bits; int nb, dc, nd, rc, de; logic [4:0] fc;
    @(negedge clk);
    cmd_data = 16'hFFFF; cmd_len = 5'd10; cmd_dir = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    n_checks++; if (!(busy === 1'b1 && sr_en === 1'b1)) $display("FAIL arst_pre got busy %b en %b want 1 1", busy, sr_en); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({sr_en, sr_d, sr_dir, busy, done} !== 5'b0)
      $display("FAIL arst_outputs got en,d,dir,busy,done=%b want 00000", {sr_en, sr_d, sr_dir, busy, done});
    else n_pass++;
    n_checks++; if (bit_cnt !== 5'd0) $display("FAIL arst_bit_cnt got %0d want 0", bit_cnt); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    run_cmd(16'h0006, 5'd3, 1'b0, -1, 0, -1, en, bits, nb, dc, nd, rc, fc, de);
    n_checks++; if (dc !== 4 || fc !== 5'd3) $display("FAIL arst_recover got done %0d cnt %0d want 4 3", dc, fc); else n_pass++;
    n_checks++; if (bits !== 16'h0006) $display("FAIL arst_recover_bits got %h want 6", bits); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, en_n, done_n, first_acc, second_acc;
    acc = 0; en_n = 0; done_n = 0; first_acc = -1; second_acc = -1;
    cmd_data = 16'h0003; cmd_len = 5'd2; cmd_dir = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (acc < 2) cmd_valid = 1'b1;
      else cmd_valid = busy;
      if (sr_en) en_n++;
      if (done) done_n++;
      if (cmd_valid && cmd_ready) begin
        if (acc == 0) first_acc = c;
        else if (acc == 1) second_acc = c;
        acc++;
      end
    end
    cmd_valid = 1'b0;
    n_checks++; if (acc !== 2) $display("FAIL b2b_accepts got %0d want 2", acc); else n_pass++;
    n_checks++; if (second_acc - first_acc !== 4) $display("FAIL b2b_gap got %0d want 4", second_acc - first_acc); else n_pass++;
    n_checks++; if (en_n !== 4 || done_n !== 2) $display("FAIL b2b_activity got en %0d done %0d want 4 2", en_n, done_n); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] en, e_en; logic [15:0] bits, d; int nb, dc, nd, rc, de; logic [4:0] fc, e_fc, len;
    int e_nb, e_dc, e_nd, e_rc, hold_at, hold_n, abort_at; logic dir;
    for (int i = 0; i < 25; i++) begin
      d = 16'($urandom); len = 5'($urandom_range(0, 31)); dir = 1'($urandom_range(0, 1));
      hold_at  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
      hold_n   = int'($urandom_range(1, 4));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_cmd(d, len, dir, hold_at, hold_n, abort_at, en, bits, nb, dc, nd, rc, fc, de);
      model_cmd(len, hold_at, hold_n, abort_at, e_en, e_nb, e_dc, e_nd, e_rc, e_fc);
      n_checks++; if (en !== e_en) $display("FAIL rnd%0d_en got %h want %h", i, en, e_en); else n_pass++;
      n_checks++; if (nb !== e_nb || bits !== (d & low_mask(e_nb)))
        $display("FAIL rnd%0d_bits got %0d/%h want %0d/%h", i, nb, bits, e_nb, d & low_mask(e_nb)); else n_pass++;
      n_checks++; if (dc !== e_dc || nd !== e_nd)
        $display("FAIL rnd%0d_done got %0d/%0d want %0d/%0d", i, dc, nd, e_dc, e_nd); else n_pass++;
      n_checks++; if (rc !== e_rc) $display("FAIL rnd%0d_ready got %0d want %0d", i, rc, e_rc); else n_pass++;
      n_checks++; if (fc !== e_fc) $display("FAIL rnd%0d_bit_cnt got %0d want %0d", i, fc, e_fc); else n_pass++;
      n_checks++; if (de !== 0) $display("FAIL rnd%0d_dir got %0d errors want 0", i, de); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full16();
    test_hold();
    test_len0_clamp();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
